// File: rtl/mem_fifo_param.sv
// Parametrised first-word-fall-through FIFO with occupancy level, almost-full/empty
// flags, synchronous flush and registered overflow/underflow pulses.
module mem_fifo_param #(
   parameter int  WIDTH      = 64,
   parameter int  DEPTH      = 4,
   parameter int  AFULL_LVL  = DEPTH-1,
   parameter int  AEMPTY_LVL = 1,
   localparam int ADDR_W     = $clog2(DEPTH)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              flush_i,
   input  logic [WIDTH-1:0]  data_in_i,
   input  logic              push_i,
   input  logic              pop_i,
   output logic [WIDTH-1:0]  data_out_o,
   output logic              accept_o,
   output logic              valid_o,
   output logic [ADDR_W:0]   level_o,
   output logic              almost_full_o,
   output logic              almost_empty_o,
   output logic              overflow_o,
   output logic              underflow_o
);

   localparam logic [ADDR_W-1:0] PTR_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_ONE  = 1;
   localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_LVL);
   localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_LVL);

   logic [WIDTH-1:0]  mem [DEPTH];
   logic [ADDR_W-1:0] rd_ptr, wr_ptr;
   logic [ADDR_W:0]   count;
   logic              overflow_q, underflow_q;
   logic              do_push, do_pop;

   // Handshake depends only on registered count, so no push/pop -> accept/valid path.
   assign valid_o        = (count != '0);
   assign accept_o       = (count != CNT_FULL);
   assign level_o        = count;
   assign almost_full_o  = (count >= AFULL_C);
   assign almost_empty_o = (count <= AEMPTY_C);
   assign data_out_o     = mem[rd_ptr];
   assign overflow_o     = overflow_q;
   assign underflow_o    = underflow_q;

   assign do_push = push_i & accept_o & ~flush_i;
   assign do_pop  = pop_i  & valid_o  & ~flush_i;

   // Storage is deliberately not reset; flush leaves contents untouched.
   always_ff @(posedge clk_i) begin
      if (do_push) mem[wr_ptr] <= data_in_i;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr      <= '0;
         wr_ptr      <= '0;
         count       <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         overflow_q  <= push_i & ~accept_o & ~flush_i;
         underflow_q <= pop_i  & ~valid_o  & ~flush_i;
         if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
         end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (do_push && !do_pop)      count <= count + CNT_ONE;
            else if (!do_push && do_pop) count <= count - CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_mem_fifo_param.sv
// Directed self-checking bench for mem_fifo_param (WIDTH=8, DEPTH=4, AFULL=3, AEMPTY=1).
module tb_mem_fifo_param;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       flush_i;
   logic [7:0] data_in_i;
   logic       push_i;
   logic       pop_i;
   logic [7:0] data_out_o;
   logic       accept_o;
   logic       valid_o;
   logic [2:0] level_o;
   logic       almost_full_o;
   logic       almost_empty_o;
   logic       overflow_o;
   logic       underflow_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   mem_fifo_param #(.WIDTH(8), .DEPTH(4), .AFULL_LVL(3), .AEMPTY_LVL(1)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .data_in_i(data_in_i),
      .push_i(push_i), .pop_i(pop_i), .data_out_o(data_out_o), .accept_o(accept_o),
      .valid_o(valid_o), .level_o(level_o), .almost_full_o(almost_full_o),
      .almost_empty_o(almost_empty_o), .overflow_o(overflow_o), .underflow_o(underflow_o)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, act, exp);
      end
   endtask

   // Advance one edge and settle 1ns past it; inputs are then changed here.
   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_in();
      push_i = 1'b0; pop_i = 1'b0; flush_i = 1'b0; data_in_i = 8'h00;
   endtask

   logic [7:0] burst [4];
   logic [7:0] wrap_exp [12];

   initial begin
      burst = '{8'h11, 8'h22, 8'h33, 8'h44};
      wrap_exp = '{8'hA0, 8'hA1, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05,
                   8'h06, 8'h07, 8'h08, 8'h09};
      rst_ni = 1'b0;
      idle_in();
      repeat (2) @(posedge clk_i);
      #1 rst_ni = 1'b1;
      step();

      // reset / idle state
      chk("rst_valid", valid_o, 0);
      chk("rst_accept", accept_o, 1);
      chk("rst_level", level_o, 0);
      chk("rst_aempty", almost_empty_o, 1);
      chk("rst_afull", almost_full_o, 0);
      chk("rst_ovf", overflow_o, 0);
      chk("rst_unf", underflow_o, 0);

      // fill to full
      for (int i = 0; i < 4; i++) begin
         push_i = 1'b1; data_in_i = burst[i];
         step();
         chk("fill_level", level_o, i + 1);
         chk("fill_afull", almost_full_o, (i + 1 >= 3) ? 1 : 0);
         chk("fill_accept", accept_o, (i == 3) ? 0 : 1);
         chk("fill_aempty", almost_empty_o, (i == 0) ? 1 : 0);
      end
      data_in_i = 8'h55;
      step();
      chk("ovf_pulse", overflow_o, 1);
      chk("ovf_level", level_o, 4);
      push_i = 1'b0;
      step();
      chk("ovf_clear", overflow_o, 0);
      for (int i = 0; i < 4; i++) begin
         chk("drain_data", data_out_o, burst[i]);
         pop_i = 1'b1;
         step();
      end
      pop_i = 1'b0;
      chk("drain_valid", valid_o, 0);
      chk("drain_unf", underflow_o, 0);

      // pointer wrap with steady level 2
      push_i = 1'b1; data_in_i = 8'hA0; step();
      data_in_i = 8'hA1; step();
      chk("wrap_start_level", level_o, 2);
      for (int i = 0; i < 10; i++) begin
         chk("wrap_head", data_out_o, wrap_exp[i]);
         push_i = 1'b1; pop_i = 1'b1; data_in_i = 8'(i);
         step();
         chk("wrap_level", level_o, 2);
         chk("wrap_ovf", overflow_o, 0);
         chk("wrap_unf", underflow_o, 0);
      end
      push_i = 1'b0;
      for (int i = 10; i < 12; i++) begin
         chk("wrap_tail", data_out_o, wrap_exp[i]);
         step();
      end
      pop_i = 1'b0;
      chk("wrap_empty", level_o, 0);

      // full + simultaneous push/pop
      for (int i = 0; i < 4; i++) begin
         push_i = 1'b1; data_in_i = 8'hB0 + 8'(i); step();
      end
      chk("full_level", level_o, 4);
      chk("full_head", data_out_o, 8'hB0);
      data_in_i = 8'hCC; pop_i = 1'b1;
      step();
      idle_in();
      chk("full_pp_ovf", overflow_o, 1);
      chk("full_pp_level", level_o, 3);
      chk("full_pp_head", data_out_o, 8'hB1);
      step();
      chk("full_pp_ovf_clr", overflow_o, 0);
      for (int i = 1; i < 4; i++) begin
         chk("full_drain", data_out_o, 8'hB0 + 8'(i));
         pop_i = 1'b1; step();
      end
      pop_i = 1'b0;
      chk("full_drain_level", level_o, 0);

      // empty + simultaneous push/pop
      push_i = 1'b1; pop_i = 1'b1; data_in_i = 8'hAA;
      step();
      idle_in();
      chk("empty_pp_unf", underflow_o, 1);
      chk("empty_pp_level", level_o, 1);
      chk("empty_pp_data", data_out_o, 8'hAA);
      chk("empty_pp_valid", valid_o, 1);
      step();
      chk("empty_pp_unf_clr", underflow_o, 0);
      pop_i = 1'b1; step(); pop_i = 1'b0;
      chk("empty_pp_drain", level_o, 0);

      // flush with concurrent push
      for (int i = 0; i < 3; i++) begin
         push_i = 1'b1; data_in_i = 8'hC1 + 8'(i); step();
      end
      chk("flush_pre_level", level_o, 3);
      flush_i = 1'b1; data_in_i = 8'h77;
      step();
      idle_in();
      chk("flush_level", level_o, 0);
      chk("flush_valid", valid_o, 0);
      chk("flush_ovf", overflow_o, 0);
      chk("flush_aempty", almost_empty_o, 1);
      push_i = 1'b1; data_in_i = 8'h88;
      step();
      push_i = 1'b0;
      chk("flush_next_data", data_out_o, 8'h88);
      chk("flush_next_level", level_o, 1);
      pop_i = 1'b1; step(); pop_i = 1'b0;

      // asynchronous reset mid-burst
      push_i = 1'b1; data_in_i = 8'hD1; step();
      data_in_i = 8'hD2; step();
      push_i = 1'b0;
      chk("arst_pre_level", level_o, 2);
      #3 rst_ni = 1'b0;
      #1;
      chk("arst_level", level_o, 0);
      chk("arst_valid", valid_o, 0);
      chk("arst_accept", accept_o, 1);
      chk("arst_aempty", almost_empty_o, 1);
      @(posedge clk_i);
      #1 rst_ni = 1'b1;
      push_i = 1'b1; data_in_i = 8'hE1; step();
      chk("arst_first", data_out_o, 8'hE1);
      data_in_i = 8'hE2; pop_i = 1'b1; step();
      idle_in();
      chk("arst_second", data_out_o, 8'hE2);
      chk("arst_post_level", level_o, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
